sdram_resp_model: RTL and testbench

SDRAM_RESP_MODEL -- requirements
Module: sdram_resp_model

---
 rtl/sdram_resp_model.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_sdram_resp_model.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sdram_resp_model.sv
// sdram_resp_model: cycle-accurate SDRAM device responder for controller
// testing. Decodes the command pins, tracks per-bank open rows and mode
// (CL/BL), stores write bursts with byte masking and returns read bursts
// through a CAS-latency pipeline with registered data/enable outputs.
//
// Optional build macro: SDRAM_RESP_CHECK_EN -- adds the protocol checker
// that drives the sticky proto_err flag. Without it proto_err is tied low.
//
// Burst FSM states:
//   state    | meaning
//   ST_IDLE  | no burst in flight; only a READ/WRITE command produces a beat
//   ST_RD    | read burst continuing; one beat per cycle into the read pipe
//   ST_WR    | write burst continuing; one beat per cycle written to storage
module sdram_resp_model #(
  parameter int DW    = 16,
  parameter int COL_W = 8,
  parameter int ROW_W = 3
) (
  input  logic            sdram_clk,
  input  logic            sdram_rst,
  input  logic            sdr_cs_n,
  input  logic            sdr_ras_n,
  input  logic            sdr_cas_n,
  input  logic            sdr_we_n,
  input  logic [1:0]      sdr_ba,
  input  logic [12:0]     sdr_addr,
  input  logic [DW/8-1:0] sdr_dqm,
  input  logic [DW-1:0]   sdr_dq_in,
  output logic [DW-1:0]   sdr_dq_out,
  output logic            sdr_dq_oe,
  output logic            proto_err
);

  localparam int NB    = DW / 8;
  localparam int IDX_W = 2 + ROW_W + COL_W;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_READ,
    CMD_WRITE,
    CMD_PRE,
    CMD_REF,
    CMD_MRS,
    CMD_BST
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR
  } state_e;

  cmd_e                        cmd;
  state_e                      state_q, state_d;
  logic [2:0]                  cl_q, cl_d;
  logic [1:0]                  bl_lg_q, bl_lg_d;
  logic [3:0]                  bank_open_q, bank_open_d;
  logic [3:0][ROW_W-1:0]       bank_row_q, bank_row_d;
  logic [1:0]                  burst_ba_q, burst_ba_d;
  logic [ROW_W-1:0]            burst_row_q, burst_row_d;
  logic [COL_W-1:0]            burst_col_q, burst_col_d;
  logic [2:0]                  burst_beat_q, burst_beat_d;
  logic                        burst_ap_q, burst_ap_d;
  logic [1:0]                  pipe_v_q, pipe_v_d;
  logic [1:0][IDX_W-1:0]       pipe_idx_q, pipe_idx_d;
  logic                        dq_oe_q, dq_oe_d;
  logic [DW-1:0]               dq_q, dq_d;

  logic [DW-1:0]               mem [DEPTH];

  logic                        burst_active;
  logic [2:0]                  bl_last;
  logic [COL_W-1:0]            bl_mask;
  logic                        a10;
  logic                        cl_ok;
  logic                        bl_ok;

  logic                        beat_v;
  logic                        beat_wr;
  logic [1:0]                  b_ba;
  logic [ROW_W-1:0]            b_row;
  logic [COL_W-1:0]            b_start;
  logic [2:0]                  b_beat;
  logic [COL_W-1:0]            b_col;
  logic [IDX_W-1:0]            beat_idx;

  logic                        tap_v;
  logic [IDX_W-1:0]            tap_idx;

  logic                        unused_addr_bits;

  assign burst_active     = (state_q != ST_IDLE);
  assign a10              = sdr_addr[10];
  assign cl_ok            = (sdr_addr[6:4] == 3'd2) || (sdr_addr[6:4] == 3'd3);
  assign bl_ok            = !sdr_addr[2];
  assign bl_mask          = {{(COL_W-3){1'b0}}, bl_last};
  assign unused_addr_bits = ^sdr_addr;

  // Command decode from the four control pins; deselect is a NOP.
  always_comb begin
    cmd = CMD_NOP;
    if (!sdr_cs_n) begin
      case ({sdr_ras_n, sdr_cas_n, sdr_we_n})
        3'b011:  cmd = CMD_ACT;
        3'b101:  cmd = CMD_READ;
        3'b100:  cmd = CMD_WRITE;
        3'b010:  cmd = CMD_PRE;
        3'b001:  cmd = CMD_REF;
        3'b000:  cmd = CMD_MRS;
        3'b110:  cmd = CMD_BST;
        default: cmd = CMD_NOP;
      endcase
    end
  end

  // Last beat number of a burst (BL-1), also the column wrap mask.
  always_comb begin
    case (bl_lg_q)
      2'd0:    bl_last = 3'd0;
      2'd1:    bl_last = 3'd1;
      2'd2:    bl_last = 3'd3;
      default: bl_last = 3'd7;
    endcase
  end

  // Beat for this cycle: a new READ/WRITE supplies beat 0 itself and
  // truncates any burst in flight; otherwise the running burst continues.
  always_comb begin
    beat_v  = 1'b0;
    beat_wr = 1'b0;
    b_ba    = burst_ba_q;
    b_row   = burst_row_q;
    b_start = burst_col_q;
    b_beat  = burst_beat_q;
    if (cmd == CMD_READ || cmd == CMD_WRITE) begin
      beat_v  = 1'b1;
      beat_wr = (cmd == CMD_WRITE);
      b_ba    = sdr_ba;
      b_row   = bank_row_q[sdr_ba];
      b_start = sdr_addr[COL_W-1:0];
      b_beat  = 3'd0;
    end else if (burst_active) begin
      beat_v  = 1'b1;
      beat_wr = (state_q == ST_WR);
    end
    b_col    = (b_start & ~bl_mask) |
               ((b_start + {{(COL_W-3){1'b0}}, b_beat}) & bl_mask);
    beat_idx = {b_ba, b_row, b_col};
  end

  // Next state for mode, banks, burst tracking and the read pipeline.
  always_comb begin
    state_d      = state_q;
    cl_d         = cl_q;
    bl_lg_d      = bl_lg_q;
    bank_open_d  = bank_open_q;
    bank_row_d   = bank_row_q;
    burst_ba_d   = burst_ba_q;
    burst_row_d  = burst_row_q;
    burst_col_d  = burst_col_q;
    burst_beat_d = burst_beat_q;
    burst_ap_d   = burst_ap_q;

    if (burst_active) begin
      if (burst_beat_q >= bl_last) begin
        state_d = ST_IDLE;
        if (burst_ap_q) begin
          bank_open_d[burst_ba_q] = 1'b0;
        end
      end else begin
        burst_beat_d = burst_beat_q + 3'd1;
      end
    end

    case (cmd)
      CMD_ACT: begin
        bank_open_d[sdr_ba] = 1'b1;
        bank_row_d[sdr_ba]  = sdr_addr[ROW_W-1:0];
      end
      CMD_READ, CMD_WRITE: begin
        // A truncated burst loses its pending auto-precharge.
        burst_ba_d   = sdr_ba;
        burst_row_d  = bank_row_q[sdr_ba];
        burst_col_d  = sdr_addr[COL_W-1:0];
        burst_beat_d = 3'd1;
        burst_ap_d   = a10;
        if (bl_lg_q == 2'd0) begin
          state_d = ST_IDLE;
          if (a10) begin
            bank_open_d[sdr_ba] = 1'b0;
          end
        end else begin
          state_d = (cmd == CMD_WRITE) ? ST_WR : ST_RD;
        end
      end
      CMD_PRE: begin
        if (a10) begin
          bank_open_d = 4'b0000;
        end else begin
          bank_open_d[sdr_ba] = 1'b0;
        end
        if (burst_active && (a10 || sdr_ba == burst_ba_q)) begin
          state_d = ST_IDLE;
        end
      end
      CMD_BST: begin
        state_d = ST_IDLE;
      end
      CMD_MRS: begin
        // Illegal fields keep their previous value.
        if (cl_ok) begin
          cl_d = sdr_addr[6:4];
        end
        if (bl_ok) begin
          bl_lg_d = sdr_addr[1:0];
        end
      end
      default: ;
    endcase

    // CL-1 index stages plus the output register give CL cycles of latency.
    pipe_v_d   = {pipe_v_q[0], beat_v & ~beat_wr};
    pipe_idx_d = {pipe_idx_q[0], beat_idx};
    tap_v      = (cl_q == 3'd3) ? pipe_v_q[1] : pipe_v_q[0];
    tap_idx    = (cl_q == 3'd3) ? pipe_idx_q[1] : pipe_idx_q[0];
    dq_oe_d    = tap_v;
    if (cmd == CMD_WRITE) begin
      pipe_v_d = 2'b00;
      dq_oe_d  = 1'b0;
    end
    dq_d = dq_oe_d ? mem[tap_idx] : '0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state_q      <= ST_IDLE;
      cl_q         <= 3'd2;
      bl_lg_q      <= 2'd0;
      bank_open_q  <= 4'b0000;
      bank_row_q   <= '0;
      burst_ba_q   <= 2'd0;
      burst_row_q  <= '0;
      burst_col_q  <= '0;
      burst_beat_q <= 3'd0;
      burst_ap_q   <= 1'b0;
      pipe_v_q     <= 2'b00;
      pipe_idx_q   <= '0;
      dq_oe_q      <= 1'b0;
      dq_q         <= '0;
    end else begin
      state_q      <= state_d;
      cl_q         <= cl_d;
      bl_lg_q      <= bl_lg_d;
      bank_open_q  <= bank_open_d;
      bank_row_q   <= bank_row_d;
      burst_ba_q   <= burst_ba_d;
      burst_row_q  <= burst_row_d;
      burst_col_q  <= burst_col_d;
      burst_beat_q <= burst_beat_d;
      burst_ap_q   <= burst_ap_d;
      pipe_v_q     <= pipe_v_d;
      pipe_idx_q   <= pipe_idx_d;
      dq_oe_q      <= dq_oe_d;
      dq_q         <= dq_d;
    end
  end

  // Byte-masked storage write; contents deliberately survive reset.
  always_ff @(posedge sdram_clk) begin
    if (!sdram_rst && beat_v && beat_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (!sdr_dqm[b]) begin
          mem[beat_idx][b*8 +: 8] <= sdr_dq_in[b*8 +: 8];
        end
      end
    end
  end

  assign sdr_dq_oe  = dq_oe_q;
  assign sdr_dq_out = dq_q;

`ifdef SDRAM_RESP_CHECK_EN
  logic err_q, err_d;
  logic err_hit;

  // Protocol violations seen on the current command.
  always_comb begin
    err_hit = 1'b0;
    case (cmd)
      CMD_ACT:             err_hit = bank_open_q[sdr_ba];
      CMD_READ, CMD_WRITE: err_hit = !bank_open_q[sdr_ba];
      CMD_REF:             err_hit = |bank_open_q;
      CMD_MRS:             err_hit = (|bank_open_q) || !cl_ok || !bl_ok;
      default:             err_hit = 1'b0;
    endcase
    err_d = err_q | err_hit;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_resp_model.sv
// Directed bench for sdram_resp_model: mode set, write/read bursts, column
// wrap, byte masking, burst stop, reset abort and the optional checker.
module tb_sdram_resp_model;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_MRS = 4'b0000;
  localparam logic [3:0] C_BST = 4'b0110;

`ifdef SDRAM_RESP_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  logic        sdram_clk = 1'b0;
  logic        sdram_rst;
  logic        sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
  logic [1:0]  sdr_ba;
  logic [12:0] sdr_addr;
  logic [1:0]  sdr_dqm;
  logic [15:0] sdr_dq_in;
  logic [15:0] sdr_dq_out;
  logic        sdr_dq_oe;
  logic        proto_err;

  int          total = 0;
  int          bad   = 0;
  logic        cap_oe [1:12];
  logic [15:0] cap_dq [1:12];

  always #5 sdram_clk = ~sdram_clk;

  sdram_resp_model #(.DW(16), .COL_W(8), .ROW_W(3)) dut (
    .sdram_clk  (sdram_clk),
    .sdram_rst  (sdram_rst),
    .sdr_cs_n   (sdr_cs_n),
    .sdr_ras_n  (sdr_ras_n),
    .sdr_cas_n  (sdr_cas_n),
    .sdr_we_n   (sdr_we_n),
    .sdr_ba     (sdr_ba),
    .sdr_addr   (sdr_addr),
    .sdr_dqm    (sdr_dqm),
    .sdr_dq_in  (sdr_dq_in),
    .sdr_dq_out (sdr_dq_out),
    .sdr_dq_oe  (sdr_dq_oe),
    .proto_err  (proto_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sdram_clk);
    @(negedge sdram_clk);
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] addr,
                       input logic [1:0] dqm, input logic [15:0] dq);
    {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = c;
    sdr_ba    = ba;
    sdr_addr  = addr;
    sdr_dqm   = dqm;
    sdr_dq_in = dq;
    step();
    {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = C_NOP;
  endtask

  // Issue a READ, then capture oe/data at each following sample point.
  // bst_at / rst_at put a BST or a reset on the cycle after capture i.
  task automatic read_cap(input logic [1:0] ba, input logic [12:0] addr, input int n,
                          input int bst_at, input int rst_at);
    drive(C_RD, ba, addr, 2'b00, 16'h0000);
    for (int i = 1; i <= n; i++) begin
      cap_oe[i] = sdr_dq_oe;
      cap_dq[i] = sdr_dq_out;
      sdram_rst = (i == rst_at);
      {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = (i == bst_at) ? C_BST : C_NOP;
      step();
    end
    sdram_rst = 1'b0;
    {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = C_NOP;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_oe;
    sdram_rst = 1'b1;
    {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = C_NOP;
    sdr_ba = 2'd0; sdr_addr = 13'h0; sdr_dqm = 2'b00; sdr_dq_in = 16'h0;
    step();
    step();
    check_val("rst_oe", sdr_dq_oe, 0);
    check_val("rst_dq", sdr_dq_out, 0);
    check_val("rst_err", proto_err, 0);
    sdram_rst = 1'b0;
    step();

    // CL3 BL4, write A0..A3 at col 0x10 of bank 0 row 1, read it back
    drive(C_MRS, 2'd0, 13'h032, 2'b00, 16'h0);
    drive(C_ACT, 2'd0, 13'h001, 2'b00, 16'h0);
    drive(C_WR,  2'd0, 13'h010, 2'b00, 16'h00A0);
    drive(C_NOP, 2'd0, 13'h000, 2'b00, 16'h00A1);
    drive(C_NOP, 2'd0, 13'h000, 2'b00, 16'h00A2);
    drive(C_NOP, 2'd0, 13'h000, 2'b00, 16'h00A3);
    step();
    read_cap(2'd0, 13'h010, 8, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      exp_oe = (i >= 3 && i <= 6);
      check_val($sformatf("cl3_oe%0d", i), cap_oe[i], exp_oe);
      check_val($sformatf("cl3_dq%0d", i), cap_dq[i], exp_oe ? 32'h00A0 + 32'(i - 3) : 32'h0);
    end

    // Wrapped burst from col 0x12: 0x12,0x13,0x10,0x11
    read_cap(2'd0, 13'h012, 7, 0, 0);
    check_val("wrap_oe2", cap_oe[2], 0);
    check_val("wrap_dq3", cap_dq[3], 16'h00A2);
    check_val("wrap_dq4", cap_dq[4], 16'h00A3);
    check_val("wrap_dq5", cap_dq[5], 16'h00A0);
    check_val("wrap_dq6", cap_dq[6], 16'h00A1);
    check_val("wrap_oe7", cap_oe[7], 0);

    // CL2 BL1 byte mask: 0x1234 then 0xFFFF with upper byte masked
    drive(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
    drive(C_MRS, 2'd0, 13'h020, 2'b00, 16'h0);
    drive(C_ACT, 2'd1, 13'h002, 2'b00, 16'h0);
    drive(C_WR,  2'd1, 13'h005, 2'b00, 16'h1234);
    drive(C_WR,  2'd1, 13'h005, 2'b10, 16'hFFFF);
    step();
    read_cap(2'd1, 13'h005, 4, 0, 0);
    check_val("mask_oe1", cap_oe[1], 0);
    check_val("mask_oe2", cap_oe[2], 1);
    check_val("mask_dq2", cap_dq[2], 16'h12FF);
    check_val("mask_oe3", cap_oe[3], 0);

    // CL2 BL8 read with BST two cycles later: three beats only
    drive(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
    drive(C_MRS, 2'd0, 13'h023, 2'b00, 16'h0);
    drive(C_ACT, 2'd0, 13'h001, 2'b00, 16'h0);
    read_cap(2'd0, 13'h010, 7, 2, 0);
    for (int i = 1; i <= 7; i++) begin
      exp_oe = (i >= 2 && i <= 4);
      check_val($sformatf("bst_oe%0d", i), cap_oe[i], exp_oe);
    end
    check_val("bst_dq2", cap_dq[2], 16'h00A0);
    check_val("bst_dq3", cap_dq[3], 16'h00A1);
    check_val("bst_dq4", cap_dq[4], 16'h00A2);
    check_val("err_legal", proto_err, 0);

    // CL2 BL4 read, reset during the second data beat
    drive(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
    drive(C_MRS, 2'd0, 13'h022, 2'b00, 16'h0);
    drive(C_ACT, 2'd0, 13'h001, 2'b00, 16'h0);
    read_cap(2'd0, 13'h010, 6, 0, 3);
    check_val("rab_oe2", cap_oe[2], 1);
    check_val("rab_dq2", cap_dq[2], 16'h00A0);
    check_val("rab_oe3", cap_oe[3], 1);
    check_val("rab_dq3", cap_dq[3], 16'h00A1);
    check_val("rab_oe4", cap_oe[4], 0);
    check_val("rab_dq4", cap_dq[4], 16'h0000);
    check_val("rab_oe5", cap_oe[5], 0);

    // After reset mode is CL2 BL1 and banks are closed
    drive(C_ACT, 2'd0, 13'h001, 2'b00, 16'h0);
    read_cap(2'd0, 13'h011, 4, 0, 0);
    check_val("post_oe1", cap_oe[1], 0);
    check_val("post_oe2", cap_oe[2], 1);
    check_val("post_dq2", cap_dq[2], 16'h00A1);
    check_val("post_oe3", cap_oe[3], 0);

    // WRITE coinciding with reset must not reach storage
    sdram_rst = 1'b1;
    drive(C_WR, 2'd0, 13'h012, 2'b00, 16'hDEAD);
    sdram_rst = 1'b0;
    drive(C_ACT, 2'd0, 13'h001, 2'b00, 16'h0);
    read_cap(2'd0, 13'h012, 3, 0, 0);
    check_val("rstwr_dq2", cap_dq[2], 16'h00A2);

    // READ to closed bank 2: sticky error (checker build only), reset clears
    drive(C_RD, 2'd2, 13'h005, 2'b00, 16'h0);
    check_val("err_set", proto_err, CHK_EN);
    step();
    step();
    check_val("err_hold", proto_err, CHK_EN);
    sdram_rst = 1'b1;
    step();
    sdram_rst = 1'b0;
    check_val("err_clr", proto_err, 0);
    check_val("err_clr_oe", sdr_dq_oe, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
